// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage to external SRAM path.
package arm_mem_pkg;

  // Access sequencer states. Each 32-bit word is split into a low and a high halfword phase.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int SRAM_DATA_W     = 16;
  localparam int SRAM_ADDR_W_DEF = 18;

  // The CPU subtracts this from load/store addresses before they reach the controller.
  localparam int DATA_MEM_OFFSET = 1024;

endpackage

// File: rtl/sram_controller.sv
// Multi-cycle controller for a 16-bit asynchronous SRAM.
// Each 32-bit access runs two halfword phases (LO, then HI) of ACCESS_CYCLES clocks each.
// ready drops combinationally so the pipeline freezes in the same cycle the request appears.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_ADDR_W   = SRAM_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  mem_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [SRAM_ADDR_W-2:0] addr_q;
  logic [31:0]            data_q;
  logic                   is_wr;
  logic                   last;

  // Byte-offset bits and bits above the SRAM range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:SRAM_ADDR_W+1], address[1:0]};

  assign last = (cnt == CNT_LAST);

  // Freeze whenever a request is present, except in the single DONE cycle.
  assign ready = ~(rd_en | wr_en) | (state == DONE);

  // Sequencer: latch request in IDLE, step through LO/HI phases, capture read halves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      is_wr     <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            addr_q <= address[SRAM_ADDR_W:2];
            data_q <= write_data;
            is_wr  <= wr_en;  // write wins if both are asserted
            cnt    <= '0;
            state  <= LO;
          end
        end
        LO: begin
          if (last) begin
            if (!is_wr) read_data[15:0] <= sram_dq_in;
            cnt   <= '0;
            state <= HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (last) begin
            if (!is_wr) read_data[31:16] <= sram_dq_in;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // SRAM pins decoded from state, counter and latched request only (Moore).
  // we_n rises on the last count of a write phase, while address and data are still held.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      LO: begin
        sram_addr = {addr_q, 1'b0};
        if (is_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = data_q[15:0];
          sram_we_n   = last;
        end
      end
      HI: begin
        sram_addr = {addr_q, 1'b1};
        if (is_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = data_q[31:16];
          sram_we_n   = last;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default timing instance plus an ACCESS_CYCLES=4 instance.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;

  // Instance with ACCESS_CYCLES = 2
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in, sram_dq_out;
  logic        sram_dq_oe, sram_we_n;

  // Instance with ACCESS_CYCLES = 4
  logic        rd_en2, wr_en2;
  logic [31:0] address2, write_data2, read_data2;
  logic        ready2;
  logic [17:0] sram_addr2;
  logic [15:0] sram_dq_in2, sram_dq_out2;
  logic        sram_dq_oe2, sram_we_n2;

  int nchecks = 0;
  int nerr    = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  sram_controller #(.ACCESS_CYCLES(2), .SRAM_ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.ACCESS_CYCLES(4), .SRAM_ADDR_W(18)) dut4 (
    .clk(clk), .rst(rst), .rd_en(rd_en2), .wr_en(wr_en2), .address(address2),
    .write_data(write_data2), .read_data(read_data2), .ready(ready2),
    .sram_addr(sram_addr2), .sram_dq_in(sram_dq_in2), .sram_dq_out(sram_dq_out2),
    .sram_dq_oe(sram_dq_oe2), .sram_we_n(sram_we_n2)
  );

  // Behavioural SRAM for the default instance: async read, write while strobe low.
  assign sram_dq_in = mem[sram_addr[7:0]];
  always @(posedge clk)
    if (sram_dq_oe && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the default instance, count frozen cycles, return data seen in DONE.
  task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, output int freeze, output logic [31:0] rdata);
    wr_en = w; rd_en = r; address = a; write_data = d;
    freeze = 0;
    #1;
    while (!ready && freeze < 50) begin
      freeze++;
      tick();
    end
    rdata = read_data;
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  initial begin
    int          n;
    logic [31:0] rd;
    logic [31:0] prev;

    rst = 1'b1;
    rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en2 = 0; wr_en2 = 0; address2 = 0; write_data2 = 0; sram_dq_in2 = 16'h5A5A;
    #2;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_ready", 32'(ready), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    // Write 0xDEADBEEF to 0x8, checking the pin sequence cycle by cycle.
    wr_en = 1; address = 32'h8; write_data = 32'hDEADBEEF;
    #1;
    chk("wr_c0_ready", 32'(ready), 32'h0);
    chk("wr_c0_we_n", 32'(sram_we_n), 32'h1);
    tick();
    chk("wr_c1_addr", 32'(sram_addr), 32'h4);
    chk("wr_c1_dq", 32'(sram_dq_out), 32'hBEEF);
    chk("wr_c1_oe", 32'(sram_dq_oe), 32'h1);
    chk("wr_c1_we_n", 32'(sram_we_n), 32'h0);
    chk("wr_c1_ready", 32'(ready), 32'h0);
    tick();
    chk("wr_c2_addr", 32'(sram_addr), 32'h4);
    chk("wr_c2_we_n", 32'(sram_we_n), 32'h1);
    chk("wr_c2_oe", 32'(sram_dq_oe), 32'h1);
    tick();
    chk("wr_c3_addr", 32'(sram_addr), 32'h5);
    chk("wr_c3_dq", 32'(sram_dq_out), 32'hDEAD);
    chk("wr_c3_we_n", 32'(sram_we_n), 32'h0);
    tick();
    chk("wr_c4_we_n", 32'(sram_we_n), 32'h1);
    chk("wr_c4_ready", 32'(ready), 32'h0);
    tick();
    chk("wr_c5_ready", 32'(ready), 32'h1);
    chk("wr_c5_oe", 32'(sram_dq_oe), 32'h0);
    chk("wr_c5_addr", 32'(sram_addr), 32'h0);
    chk("wr_read_data_kept", read_data, 32'h0);
    wr_en = 0;
    tick();
    chk("wr_idle_ready", 32'(ready), 32'h1);

    // Read back from 0x8.
    do_access(1'b0, 1'b1, 32'h8, 32'h0, n, rd);
    chk("rd8_freeze", 32'(n), 32'd5);
    chk("rd8_data", rd, 32'hDEADBEEF);

    // Populate 0x0 and 0x4, then read them back to back.
    do_access(1'b1, 1'b0, 32'h0, 32'h11112222, n, rd);
    do_access(1'b1, 1'b0, 32'h4, 32'h33334444, n, rd);
    do_access(1'b0, 1'b1, 32'h0, 32'h0, n, rd);
    chk("b2b_rd0_freeze", 32'(n), 32'd5);
    chk("b2b_rd0_data", rd, 32'h11112222);
    do_access(1'b0, 1'b1, 32'h4, 32'h0, n, rd);
    chk("b2b_rd4_freeze", 32'(n), 32'd5);
    chk("b2b_rd4_data", rd, 32'h33334444);

    // Both strobes high: write wins, read_data untouched.
    prev = 32'h33334444;
    do_access(1'b1, 1'b1, 32'h10, 32'h12345678, n, rd);
    chk("both_freeze", 32'(n), 32'd5);
    chk("both_read_data_kept", rd, prev);
    do_access(1'b0, 1'b1, 32'h10, 32'h0, n, rd);
    chk("both_written", rd, 32'h12345678);

    // Reset in the middle of the HI phase of a write.
    wr_en = 1; address = 32'hC; write_data = 32'hAAAA5555;
    tick(); tick(); tick();
    chk("rstmid_pre_we_n", 32'(sram_we_n), 32'h0);
    chk("rstmid_pre_addr", 32'(sram_addr), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_we_n", 32'(sram_we_n), 32'h1);
    chk("rstmid_oe", 32'(sram_dq_oe), 32'h0);
    chk("rstmid_read_data", read_data, 32'h0);
    chk("rstmid_ready_req", 32'(ready), 32'h0);
    wr_en = 0;
    #1;
    chk("rstmid_ready", 32'(ready), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    // ACCESS_CYCLES=4: SRAM data is only correct on the last count of each phase.
    rd_en2 = 1; address2 = 32'h20;
    n = -1;
    for (int c = 0; c < 20; c++) begin
      sram_dq_in2 = (c == 4) ? 16'hF00D : (c == 8) ? 16'hCAFE : 16'h5A5A;
      #1;
      if (c == 4) chk("a4_lo_addr", 32'(sram_addr2), 32'h10);
      if (c == 8) chk("a4_hi_addr", 32'(sram_addr2), 32'h11);
      if (ready2) begin
        n = c;
        break;
      end
      tick();
    end
    chk("a4_freeze", 32'(n), 32'd9);
    chk("a4_data", read_data2, 32'hCAFEF00D);
    rd_en2 = 0;
    tick();
    chk("a4_idle_ready", 32'(ready2), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
